// File: rtl/wisc_pkg.sv
`default_nettype none
// ============================================================================
// wisc_pkg
// ----------------------------------------------------------------------------
// Types and constants shared by the WISC core blocks: the data word width,
// the data-memory responder FSM states and the memory operation encoding
// that the instruction decoder also uses.
// Revision: 1.0 - initial release
// ============================================================================
package wisc_pkg;

  localparam int DATA_W     = 16;
  // Latency counter width; LATENCY is limited to 1..15.
  localparam int DMEM_CNT_W = 4;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_BUSY = 2'd1,
    DM_DONE = 2'd2
  } dmem_state_e;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_e;

  // Map a one-hot rd/wr request to its operation code.
  function automatic mem_op_e mem_op_of(input logic wr_en);
    return wr_en ? MEM_WR : MEM_RD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// dmem_array
// ----------------------------------------------------------------------------
// 2**DEPTH_LOG2 words x DATA_W storage. Synchronous write, registered read
// with an enable so the read register holds its value between loads.
// The storage itself is not reset; only the read register is cleared.
// Ports:
//   clk, rst_n      : clock, async active-low reset (read register only)
//   we, waddr, wdata: write port
//   re, raddr       : read request, captured on the clock edge
//   rdata           : registered read data (holds until the next read)
// Revision: 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder
// ----------------------------------------------------------------------------
// Memory side of the decoder's dm_rd_en/dm_wr_en interface. Accepts one
// load or store at a time, holds it for LATENCY cycles (stall high while
// busy), then pulses done for one cycle; a load returns rdata on that pulse.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   dm_rd_en, dm_wr_en : load / store request (both high = error)
//   addr               : byte address, bit 0 ignored, upper bits wrap
//   wdata              : store data
//   rdata              : last loaded word (updates only when a load completes)
//   done               : one-cycle completion pulse
//   stall              : operation in flight
//   err                : one-cycle pulse after a rd+wr conflict
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DATA_W     = wisc_pkg::DATA_W,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dm_rd_en,
  input  logic              dm_wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              stall,
  output logic              err
);

  import wisc_pkg::*;

  dmem_state_e             state;
  logic [DMEM_CNT_W-1:0]   count;
  mem_op_e                 op_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_W-1:0]       wdata_q;

  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    can_accept;
  logic                    accept;
  logic                    conflict;
  logic                    complete;
  mem_op_e                 cmp_op;
  logic [DEPTH_LOG2-1:0]   cmp_idx;
  logic [DATA_W-1:0]       cmp_wdata;
  logic                    unused_addr_bits;

  // Word index: byte-lane bit dropped, bits above the array depth wrap.
  assign req_idx          = addr[DEPTH_LOG2:1];
  assign unused_addr_bits = ^{addr[ADDR_W-1:DEPTH_LOG2+1], addr[0]};

  // DONE behaves like IDLE for acceptance, giving zero-gap back-to-back ops.
  assign can_accept = (state != DM_BUSY);
  assign accept     = can_accept && (dm_rd_en ^ dm_wr_en);
  assign conflict   = can_accept && dm_rd_en && dm_wr_en;

  // The memory access happens on the edge that moves the FSM into DONE.
  // With LATENCY=1 that is the acceptance edge itself, so the live request
  // is used instead of the latched copy.
  always_comb begin
    complete  = 1'b0;
    cmp_op    = op_q;
    cmp_idx   = idx_q;
    cmp_wdata = wdata_q;
    if (LATENCY == 1) begin
      complete  = accept;
      cmp_op    = mem_op_of(dm_wr_en);
      cmp_idx   = req_idx;
      cmp_wdata = wdata;
    end else begin
      complete  = (state == DM_BUSY) && (count <= DMEM_CNT_W'(1));
    end
  end

  // A store is only written on completion, so a reset while busy leaves
  // the array untouched; a load only updates rdata on completion.
  dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (complete && (cmp_op == MEM_WR)),
    .waddr (cmp_idx),
    .wdata (cmp_wdata),
    .re    (complete && (cmp_op == MEM_RD)),
    .raddr (cmp_idx),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DM_IDLE;
      count   <= '0;
      op_q    <= MEM_RD;
      idx_q   <= '0;
      wdata_q <= '0;
      done    <= 1'b0;
      stall   <= 1'b0;
      err     <= 1'b0;
    end else begin
      done  <= 1'b0;
      stall <= 1'b0;
      err   <= 1'b0;
      case (state)
        DM_IDLE, DM_DONE: begin
          err <= conflict;
          if (accept) begin
            op_q    <= mem_op_of(dm_wr_en);
            idx_q   <= req_idx;
            wdata_q <= wdata;
            count   <= DMEM_CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              state <= DM_DONE;
              done  <= 1'b1;
            end else begin
              state <= DM_BUSY;
              stall <= 1'b1;
            end
          end else begin
            state <= DM_IDLE;
          end
        end
        DM_BUSY: begin
          // count reaches 0 on this edge: LATENCY-1 busy cycles in total.
          if (count <= DMEM_CNT_W'(1)) begin
            count <= '0;
            state <= DM_DONE;
            done  <= 1'b1;
          end else begin
            count <= count - DMEM_CNT_W'(1);
            stall <= 1'b1;
          end
        end
        default: state <= DM_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder
// ----------------------------------------------------------------------------
// Self-checking bench for dmem_responder. Two instances: LATENCY=4 (index 0)
// and LATENCY=1 (index 1). A word-array model of memory contents and the
// last returned load value gives every expected output.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int LAT [2] = '{4, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en   [2];
  logic        wr_en   [2];
  logic [15:0] addr_i  [2];
  logic [15:0] wdata_i [2];
  logic [15:0] rdata_o [2];
  logic        done_o  [2];
  logic        stall_o [2];
  logic        err_o   [2];

  int checks   = 0;
  int failures = 0;

  // Reference model: memory contents per instance plus written flags.
  logic [15:0] mem_m   [2][1024];
  bit          wr_m    [2][1024];
  logic [15:0] last_rd [2];
  bit          rd_known[2];

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .dm_rd_en(rd_en[0]), .dm_wr_en(wr_en[0]),
    .addr(addr_i[0]), .wdata(wdata_i[0]), .rdata(rdata_o[0]),
    .done(done_o[0]), .stall(stall_o[0]), .err(err_o[0])
  );

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .dm_rd_en(rd_en[1]), .dm_wr_en(wr_en[1]),
    .addr(addr_i[1]), .wdata(wdata_i[1]), .rdata(rdata_o[1]),
    .done(done_o[1]), .stall(stall_o[1]), .err(err_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < 2; s++) begin
      rd_en[s] = 1'b0; wr_en[s] = 1'b0; addr_i[s] = '0; wdata_i[s] = '0;
    end
  endtask

  // Idle cycles: nothing may be in flight on either instance.
  task automatic idle(input int n);
    clear_inputs();
    repeat (n) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("idle_done%0d", s), done_o[s], 0);
        chk($sformatf("idle_stall%0d", s), stall_o[s], 0);
      end
    end
  endtask

  // One operation, entered at a negedge with the instance idle or in DONE.
  // Returns at the negedge of the DONE cycle with the request still driven;
  // the caller follows with another op on the same instance or idle().
  task automatic op(input int s, input bit rd, input logic [15:0] a,
                    input logic [15:0] d, input bit chk_rd = 1'b1);
    int idx;
    idx = int'((a >> 1) % 16'd1024);
    rd_en[s] = rd; wr_en[s] = !rd; addr_i[s] = a; wdata_i[s] = d;
    @(posedge clk);
    for (int k = 1; k <= LAT[s]; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_c%0d", s, k), stall_o[s], (k < LAT[s]) ? 1 : 0);
      chk($sformatf("done%0d_c%0d", s, k), done_o[s], (k == LAT[s]) ? 1 : 0);
      chk($sformatf("err%0d_c%0d", s, k), err_o[s], 0);
      if (k < LAT[s] && rd_known[s])
        chk($sformatf("rdhold%0d_c%0d", s, k), rdata_o[s], last_rd[s]);
    end
    if (!rd) begin
      mem_m[s][idx] = d;
      wr_m[s][idx]  = 1'b1;
      if (rd_known[s]) chk($sformatf("rdhold%0d_st", s), rdata_o[s], last_rd[s]);
    end else if (chk_rd && wr_m[s][idx]) begin
      chk($sformatf("rdata%0d_a%0h", s, a), rdata_o[s], mem_m[s][idx]);
      last_rd[s]  = mem_m[s][idx];
      rd_known[s] = 1'b1;
    end else begin
      rd_known[s] = 1'b0;
    end
  endtask

  // Both enables high: ignored, err pulses once, no done.
  task automatic conflict(input int s, input logic [15:0] a, input logic [15:0] d);
    rd_en[s] = 1'b1; wr_en[s] = 1'b1; addr_i[s] = a; wdata_i[s] = d;
    @(posedge clk);
    #1 clear_inputs();
    @(negedge clk);
    chk($sformatf("cerr%0d", s), err_o[s], 1);
    chk($sformatf("cdone%0d", s), done_o[s], 0);
    chk($sformatf("cstall%0d", s), stall_o[s], 0);
    @(negedge clk);
    chk($sformatf("cerr%0d_off", s), err_o[s], 0);
    chk($sformatf("cdone%0d_off", s), done_o[s], 0);
  endtask

  initial begin
    logic [15:0] a;
    int idx;
    int r;

    clear_inputs();
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      last_rd[s] = '0; rd_known[s] = 1'b1;
      for (int i = 0; i < 1024; i++) begin mem_m[s][i] = '0; wr_m[s][i] = 1'b0; end
    end

    // Reset with a load request held: outputs stay 0.
    rd_en[0] = 1'b1; addr_i[0] = 16'h0010;
    repeat (3) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("rst_done%0d", s), done_o[s], 0);
        chk($sformatf("rst_stall%0d", s), stall_o[s], 0);
        chk($sformatf("rst_err%0d", s), err_o[s], 0);
        chk($sformatf("rst_rdata%0d", s), rdata_o[s], 0);
      end
    end
    rst_n = 1'b1;
    // Held request is accepted on the first edge; contents undefined.
    op(0, 1'b1, 16'h0010, 16'h0000, 1'b0);
    idle(2);

    // Directed, LATENCY=4: store then back-to-back load via the odd address.
    op(0, 1'b0, 16'h0010, 16'hBEEF);
    op(0, 1'b1, 16'h0011, 16'h0000);
    idle(1);
    op(0, 1'b1, 16'h0010, 16'h0000);
    conflict(0, 16'h0010, 16'hDEAD);
    idle(1);
    op(0, 1'b1, 16'h0010, 16'h0000);
    // Aliasing: 0x0810 is word 0x008, same as 0x0010.
    op(0, 1'b0, 16'h0810, 16'hCAFE);
    op(0, 1'b1, 16'h0010, 16'h0000);
    idle(1);

    // Reset during a store's busy phase: the store must be discarded.
    op(0, 1'b0, 16'h0020, 16'h5A5A);
    rd_en[0] = 1'b0; wr_en[0] = 1'b1; addr_i[0] = 16'h0020; wdata_i[0] = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    chk("mid_stall", stall_o[0], 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", stall_o[0], 0);
    chk("mid_rst_done", done_o[0], 0);
    chk("mid_rst_rdata", rdata_o[0], 0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin last_rd[s] = '0; rd_known[s] = 1'b1; end
    idle(2);
    op(0, 1'b1, 16'h0020, 16'h0000);
    idle(1);

    // Directed, LATENCY=1.
    op(1, 1'b0, 16'h0010, 16'hBEEF);
    op(1, 1'b1, 16'h0011, 16'h0000);
    op(1, 1'b0, 16'h0810, 16'h7777);
    op(1, 1'b1, 16'h0010, 16'h0000);
    conflict(1, 16'h0010, 16'hDEAD);
    op(1, 1'b1, 16'h0010, 16'h0000);
    idle(2);

    // Randomized traffic on each instance.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 40; i++) begin
        r = int'($urandom_range(0, 9));
        a = 16'(($urandom_range(0, 31) << 11) | ($urandom_range(0, 15) << 1)
                | $urandom_range(0, 1));
        idx = int'((a >> 1) % 16'd1024);
        if (r == 0) begin
          conflict(s, a, 16'($urandom));
        end else if (r == 1) begin
          idle(int'($urandom_range(1, 3)));
        end else if (r < 6 || !wr_m[s][idx]) begin
          op(s, 1'b0, a, 16'($urandom));
        end else begin
          op(s, 1'b1, a, 16'($urandom));
        end
      end
      idle(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the memory side of the `dm_rd_en`/`dm_wr_en` interface driven by the instruction decoder. It accepts one load or store at a time and holds the request for a fixed, parameterized latency. While busy it asserts `stall` so the pipeline freezes. It signals completion with a one-cycle `done` pulse, and on that pulse returns `rdata` for a load.

## Interface
- `DATA_W`, 16: data word width in bits.
- `ADDR_W`, 16: width of the byte address.
- `DEPTH_LOG2`, 10: log2 of the number of words stored (1024 words).
- `LATENCY`, 4: cycles from request acceptance to `done`; legal range 1..15.

- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `dm_rd_en`  in  1: load request.
- `dm_wr_en`  in  1: store request.
- `addr`  in  ADDR_W: byte address; bit 0 is ignored.
- `wdata`  in  DATA_W: store data.
- `rdata`  out  DATA_W: load data; valid only while `done`=1 for a load.
- `done`  out  1: one-cycle completion pulse.
- `stall`  out  1: request in flight; the initiator must hold its request inputs.
- `err`  out  1: one-cycle pulse when `dm_rd_en` and `dm_wr_en` are both high at acceptance.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - BUSY: counter running.
  - DONE: one cycle; `done`=1.
- IDLE, exactly one of `dm_rd_en`/`dm_wr_en` high:
  - Latch the operation, the word index `addr[DEPTH_LOG2:1]` and `wdata`.
  - Load counter with LATENCY-1.
  - Go to BUSY, or straight to DONE if LATENCY=1.
- IDLE, both enables high:
  - Request ignored; `err` pulses the next cycle.
  - State stays IDLE; no memory access.
- IDLE, neither enable high: no action.
- BUSY:
  - Counter decrements each cycle.
  - At 0, the store is committed to the array or the load word is captured into `rdata`; go to DONE.
  - Request inputs are not sampled.
- DONE:
  - `done`=1, `stall`=0.
  - A new request on the same cycle is accepted as in IDLE, so back-to-back operations have zero idle gap.
  - With no request, go to IDLE.
- `rdata` holds its last captured value. It changes only when a load completes.
- Address wraps: bits above DEPTH_LOG2 are ignored.
- The memory array is not reset; its contents are undefined until written.
- Reset mid-operation:
  - FSM returns to IDLE.
  - A pending store is discarded; the array is unchanged.
  - A pending load returns nothing.

## Timing
- Reset values: `stall`=0, `done`=0, `err`=0, `rdata`=0, FSM=IDLE, counter=0.
- Request accepted at edge T:
  - `stall`=1 for cycles T+1 .. T+LATENCY-1.
  - `done`=1 in cycle T+LATENCY.
  - `rdata` is valid in that same cycle.
- A store is visible to a load accepted in or after its DONE cycle.
- Throughput: one operation per LATENCY cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `wisc_pkg`:
  - `DATA_W`.
  - The dmem FSM state typedef (IDLE/BUSY/DONE).
  - Memory op encoding (`MEM_RD`, `MEM_WR`), reused by the decoder.
- One sub-module, `dmem_array`: a DEPTH-word × DATA_W storage with synchronous write and a read registered on `clk`, with no reset.
- The FSM, counter and request latches live in `dmem_responder`.

## Test plan
- Reset with `dm_rd_en` held high, then release → no `done` before the request is accepted. All outputs stay 0 during reset.
- Store 0xBEEF to addr 0x0010, then load addr 0x0010 with LATENCY=4:
  - Store `done` 4 cycles after acceptance.
  - Load `done` 4 cycles after its acceptance with `rdata`=0xBEEF.
  - `stall`=1 for 3 cycles in each operation.
- Back-to-back: a load issued in the store's DONE cycle is accepted there, with no IDLE cycle. Addr 0x0011 behaves as 0x0010 (bit 0 ignored).
- Both enables high in IDLE → `err` pulses once, no `done`, memory unchanged (a subsequent load returns the prior value).
- Assert `rst_n`=0 during BUSY of a store of 0x1234 to 0x0020, then a load of 0x0020 → returns the pre-reset contents, not 0x1234. Also run with LATENCY=1: `done` one cycle after acceptance, `stall` never asserted.
- Addr 0x0810 with DEPTH_LOG2=10 → aliases word 0x008; a store/load round-trip through 0x0010 returns the same data.
